// File: rtl/pipe_stage_ctrl.sv
// rtl/pipe_stage_ctrl.sv - single pipeline-stage controller with payload register
// Valid/allowin handshake on both sides, per-item countdown stall, flush, retired counter.
module pipe_stage_ctrl #(
  parameter int WIDTH = 32,
  parameter int CW    = 4,
  parameter int RCW   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CW-1:0]    in_cycles,
  output logic             allowin,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             down_allowin,
  input  logic             flush,
  output logic [RCW-1:0]   retired
);

  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [RCW-1:0] RET_ONE = RCW'(1);

  logic             valid;
  logic [WIDTH-1:0] data;
  logic [CW-1:0]    cnt;
  logic [RCW-1:0]   ret_cnt;
  logic             ready_go;
  logic             accept;
  logic             leave;

  assign ready_go  = valid & (cnt == '0);
  assign out_valid = ready_go;
  assign allowin   = ~valid | (ready_go & down_allowin) | flush;
  assign accept    = in_valid & allowin & ~flush;
  assign leave     = ready_go & down_allowin & ~flush;
  assign out_data  = data;
  assign retired   = ret_cnt;

  // Accept takes priority over leave so a departing item is replaced on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      cnt   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      valid <= 1'b1;
      cnt   <= in_cycles;
    end else if (leave) begin
      valid <= 1'b0;
    end else if (valid && cnt != '0) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  // Payload bank loads only on accept and otherwise holds, including across flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (accept) begin
      data <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_cnt <= '0;
    end else if (leave) begin
      ret_cnt <= ret_cnt + RET_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb/tb_pipe_stage_ctrl.sv - self-checking bench for pipe_stage_ctrl
// Timestamp-based item model plus directed literal checks.
module tb_pipe_stage_ctrl;

  localparam int WIDTH = 32;
  localparam int CW    = 4;
  localparam int RCW   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [CW-1:0]    in_cycles;
  logic             allowin;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             down_allowin;
  logic             flush;
  logic [RCW-1:0]   retired;

  int nvec = 0;
  int nerr = 0;

  pipe_stage_ctrl #(.WIDTH(WIDTH), .CW(CW), .RCW(RCW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_cycles(in_cycles), .allowin(allowin), .out_valid(out_valid),
    .out_data(out_data), .down_allowin(down_allowin), .flush(flush),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // Model: the held item becomes ready at a cycle timestamp, not via a countdown.
  int          cyc = 0;
  bit          m_valid = 0;
  logic [31:0] m_data = 0;
  int          m_rdy = 0;
  int          m_ret = 0;

  always @(posedge clk) begin
    bit rg, ai, acc, lv;
    rg  = m_valid && (cyc >= m_rdy);
    ai  = !m_valid || (rg && down_allowin) || flush;
    acc = in_valid && ai && !flush;
    lv  = rg && down_allowin && !flush;
    cyc = cyc + 1;
    if (rst) begin
      m_valid = 0;
      m_data  = 0;
      m_ret   = 0;
    end else begin
      if (lv) m_ret = (m_ret + 1) % (1 << RCW);
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1;
        m_data  = in_data;
        m_rdy   = cyc + int'(in_cycles);
      end else if (lv) m_valid = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      bit e_ov, e_ai;
      e_ov = m_valid && (cyc >= m_rdy);
      e_ai = !m_valid || (e_ov && down_allowin) || flush;
      chk("model out_valid", {31'b0, out_valid}, {31'b0, e_ov});
      chk("model allowin", {31'b0, allowin}, {31'b0, e_ai});
      chk("model retired", {28'b0, retired}, m_ret[31:0]);
      if (e_ov) chk("model out_data", out_data, m_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive(input bit iv, input logic [31:0] d, input int nc);
    in_valid  = iv;
    in_data   = d;
    in_cycles = CW'(nc);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = 0; in_cycles = 0; down_allowin = 1; flush = 0;
    tick(); tick();
    rst = 0;
    settle();
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset out_data", out_data, 32'd0);
    chk("reset retired", {28'b0, retired}, 32'd0);
    chk("reset allowin", {31'b0, allowin}, 32'd1);

    // Streaming, zero-cycle items
    drive(1, 32'h11, 0); tick(); settle();
    chk("stream 0x11", out_data, 32'h11);
    drive(1, 32'h22, 0); tick(); settle();
    chk("stream 0x22", out_data, 32'h22);
    drive(1, 32'h33, 0); tick(); settle();
    chk("stream 0x33", out_data, 32'h33);
    chk("stream allowin", {31'b0, allowin}, 32'd1);
    drive(0, 0, 0); tick(); settle();
    chk("stream retired", {28'b0, retired}, 32'd3);

    // Multi-cycle item
    drive(1, 32'hAB, 3); tick(); drive(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("mc out_valid low", {31'b0, out_valid}, 32'd0);
      chk("mc allowin low", {31'b0, allowin}, 32'd0);
      tick();
    end
    settle();
    chk("mc out_valid high", {31'b0, out_valid}, 32'd1);
    chk("mc out_data", out_data, 32'hAB);
    tick(); settle();
    chk("mc retired", {28'b0, retired}, 32'd4);

    // Downstream backpressure with a queued item
    down_allowin = 0;
    drive(1, 32'h5, 0); tick();
    drive(1, 32'h6, 0);
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("bp out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp out_data", out_data, 32'h5);
      chk("bp allowin", {31'b0, allowin}, 32'd0);
      chk("bp retired", {28'b0, retired}, 32'd4);
      tick();
    end
    down_allowin = 1;
    settle();
    chk("bp release allowin", {31'b0, allowin}, 32'd1);
    tick(); settle();
    chk("bp next data", out_data, 32'h6);
    chk("bp retired after", {28'b0, retired}, 32'd5);
    drive(0, 0, 0); tick();

    // Flush during countdown with an offered item
    drive(1, 32'h77, 3); tick();
    drive(0, 0, 0); tick();
    flush = 1; drive(1, 32'h88, 0);
    settle();
    chk("flush allowin", {31'b0, allowin}, 32'd1);
    tick();
    flush = 0; drive(0, 0, 0);
    settle();
    chk("flush out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush allowin after", {31'b0, allowin}, 32'd1);
    chk("flush retired", {28'b0, retired}, 32'd6);
    chk("flush data held", out_data, 32'h77);
    tick(); settle();
    chk("flush no load", {31'b0, out_valid}, 32'd0);

    // Retired counter wrap
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 17; i++) begin
      drive(1, 32'h100 + 32'(i), 0); tick();
    end
    drive(0, 0, 0); tick(); settle();
    chk("wrap retired", {28'b0, retired}, 32'd1);

    // Reset during a countdown
    drive(1, 32'hCD, 5); tick();
    drive(0, 0, 0); tick();
    rst = 1; tick(); rst = 0;
    settle();
    chk("midrst out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst out_data", out_data, 32'd0);
    chk("midrst retired", {28'b0, retired}, 32'd0);
    chk("midrst allowin", {31'b0, allowin}, 32'd1);
    for (int i = 0; i < 6; i++) tick();
    settle();
    chk("midrst aborted", {31'b0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
